alu: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_core.sv | 73 +++++++
 rtl/alu.sv | 79 +++++++
 tb/tb_alu.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational decode/compute for the ALU; flag outputs exist only when ALU_FLAGS_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluControl,
  output logic [WIDTH-1:0] result_next,
`ifdef ALU_FLAGS_EN
  output logic             negative_next,
  output logic             carry_next,
  output logic             overflow_next,
`endif
  output logic             zero_next
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

`ifdef ALU_FLAGS_EN
  // Extended adders expose carry-out; for subtraction it is NOT borrow (a >= b unsigned).
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic           add_ovf;
  logic           sub_ovf;

  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign sum     = add_ext[WIDTH-1:0];
  assign diff    = sub_ext[WIDTH-1:0];
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`else
  assign sum  = a + b;
  assign diff = a - b;
`endif

  always_comb begin
    result_next = '0;
`ifdef ALU_FLAGS_EN
    carry_next    = 1'b0;
    overflow_next = 1'b0;
`endif
    case (aluControl)
      ALU_AND:   result_next = a & b;
      ALU_OR:    result_next = a | b;
      ALU_ADD: begin
        result_next = sum;
`ifdef ALU_FLAGS_EN
        carry_next    = add_ext[WIDTH];
        overflow_next = add_ovf;
`endif
      end
      ALU_SUB: begin
        result_next = diff;
`ifdef ALU_FLAGS_EN
        carry_next    = sub_ext[WIDTH];
        overflow_next = sub_ovf;
`endif
      end
      ALU_PASSB: result_next = b;
      default:   result_next = '0;
    endcase
  end

  assign zero_next = (result_next == '0);
`ifdef ALU_FLAGS_EN
  assign negative_next = result_next[WIDTH-1];
`endif

endmodule

// File: rtl/alu.sv
// Registered ALU top: one-cycle latency, hold on !in_valid. Optional flags via ALU_FLAGS_EN.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluControl,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ALU_FLAGS_EN
  output logic             negative,
  output logic             carry,
  output logic             overflow,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             vld_q;
`ifdef ALU_FLAGS_EN
  logic             neg_d, neg_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a            (a),
    .b            (b),
    .aluControl   (aluControl),
    .result_next  (result_d),
`ifdef ALU_FLAGS_EN
    .negative_next(neg_d),
    .carry_next   (carry_d),
    .overflow_next(ovf_d),
`endif
    .zero_next    (zero_d)
  );

  // Output register stage: reset wins, otherwise capture only on valid input.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      vld_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        zero_q   <= zero_d;
`ifdef ALU_FLAGS_EN
        neg_q    <= neg_d;
        carry_q  <= carry_d;
        ovf_q    <= ovf_d;
`endif
      end
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;
`ifdef ALU_FLAGS_EN
  assign negative  = neg_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a, b;
  logic [3:0]  aluControl;
  logic        in_valid;
  logic [63:0] result;
  logic        zero;
  logic        out_valid;
`ifdef ALU_FLAGS_EN
  logic        negative, carry, overflow;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .aluControl(aluControl),
    .in_valid  (in_valid),
    .result    (result),
    .zero      (zero),
`ifdef ALU_FLAGS_EN
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
`endif
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one operation, then check the registered outputs #1 after the capturing edge.
  task automatic op(input string tag, input logic [3:0] ctl, input logic [63:0] aa,
                    input logic [63:0] bb, input logic [63:0] er, input logic ez);
    a          = aa;
    b          = bb;
    aluControl = ctl;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".res"}, result, er);
    chk({tag, ".zero"}, {63'd0, zero}, {63'd0, ez});
    chk({tag, ".vld"}, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    aluControl = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.res", result, 64'd0);
    chk("rst.zero", {63'd0, zero}, 64'd1);
    chk("rst.vld", {63'd0, out_valid}, 64'd0);
`ifdef ALU_FLAGS_EN
    chk("rst.flags", {61'd0, negative, carry, overflow}, 64'd0);
`endif
    reset = 1'b0;

    // Back-to-back stream: each result checked the cycle after its inputs.
    op("and1", 4'b0000, 64'b01010, 64'b10101, 64'd0, 1'b1);
    op("and2", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF9,
       64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    op("or1",  4'b0001, 64'b01010, 64'b10101, 64'b11111, 1'b0);
    op("or2",  4'b0001, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("or2.flags", {61'd0, negative, carry, overflow}, 64'b100);
`endif
    op("add1", 4'b0010, 64'd9, 64'd4, 64'd13, 1'b0);
    op("add2", 4'b0010, -64'sd3, -64'sd7, -64'sd10, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("add2.flags", {61'd0, negative, carry, overflow}, 64'b110);
`endif
    op("add3", 4'b0010, 64'd3, -64'sd7, -64'sd4, 1'b0);
    op("add4", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
`ifdef ALU_FLAGS_EN
    chk("add4.flags", {61'd0, negative, carry, overflow}, 64'b010);
    op("addovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0);
    chk("addovf.flags", {61'd0, negative, carry, overflow}, 64'b101);
`endif
    op("sub1", 4'b0110, 64'd9, 64'd4, 64'd5, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("sub1.flags", {61'd0, negative, carry, overflow}, 64'b010);
`endif
    op("sub2", 4'b0110, -64'sd3, -64'sd7, 64'd4, 1'b0);
    op("sub3", 4'b0110, 64'd3, -64'sd7, 64'd10, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("sub3.flags", {61'd0, negative, carry, overflow}, 64'b000);
    op("subovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    chk("subovf.flags", {61'd0, negative, carry, overflow}, 64'b011);
`endif
    op("sub4", 4'b0110, 64'd5, 64'd5, 64'd0, 1'b1);
    op("passb", 4'b0111, 64'hDEAD, 64'b10101, 64'b10101, 1'b0);
    op("illegal", 4'b0011, 64'd9, 64'd4, 64'd0, 1'b1);
`ifdef ALU_FLAGS_EN
    chk("illegal.flags", {61'd0, negative, carry, overflow}, 64'b000);
`endif

    // Hold: in_valid low keeps result/zero, out_valid drops.
    op("pre_hold", 4'b0010, 64'd9, 64'd4, 64'd13, 1'b0);
    in_valid   = 1'b0;
    a          = 64'd100;
    b          = 64'd100;
    aluControl = 4'b0110;
    @(posedge clk); #1;
    chk("hold.res", result, 64'd13);
    chk("hold.zero", {63'd0, zero}, 64'd0);
    chk("hold.vld", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream discards the operation sampled on that edge.
    op("pre_rst", 4'b0001, 64'd6, 64'd1, 64'd7, 1'b0);
    a          = 64'd1;
    b          = 64'd2;
    aluControl = 4'b0010;
    in_valid   = 1'b1;
    reset      = 1'b1;
    @(posedge clk); #1;
    chk("midrst.res", result, 64'd0);
    chk("midrst.zero", {63'd0, zero}, 64'd1);
    chk("midrst.vld", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    op("post_rst", 4'b0010, 64'd1, 64'd2, 64'd3, 1'b0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
